// File: rtl/sm_control.sv
// Control FSM for a 4-bit shift-and-add multiplier: sequences load, clear,
// conditional add and shift of the running sum, then holds DONE until start drops.
module sm_control #(
  parameter int unsigned NUM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          reset_state,
  input  logic                start,
  input  logic [NUM_BITS-1:0] mr,
  output logic                mdld,
  output logic                mrld,
  output logic                rsload,
  output logic                rsclear,
  output logic                rsshr,
  output logic [3:0]          s,
  output logic [3:0]          n,
  output logic                done
);

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    INIT = 4'd1,
    ADD0 = 4'd2,
    SH0  = 4'd3,
    ADD1 = 4'd4,
    SH1  = 4'd5,
    ADD2 = 4'd6,
    SH2  = 4'd7,
    ADD3 = 4'd8,
    SH3  = 4'd9,
    DONE = 4'd10
  } state_e;

  // Kept as a plain vector so the illegal codes 11-15 can be loaded and decoded.
  logic [3:0] state_q;
  logic [3:0] cur;
  state_e     state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= reset_state;
    else     state_q <= state_d;
  end

  // While rst is held the visible state tracks reset_state without waiting for an edge.
  assign cur = rst ? reset_state : state_q;
  assign s   = cur;
  assign n   = state_d;

  always_comb begin
    state_d = IDLE;
    mdld    = 1'b0;
    mrld    = 1'b0;
    rsload  = 1'b0;
    rsclear = 1'b0;
    rsshr   = 1'b0;
    done    = 1'b0;
    case (cur)
      IDLE: state_d = start ? INIT : IDLE;
      INIT: begin
        mdld    = 1'b1;
        mrld    = 1'b1;
        rsclear = 1'b1;
        state_d = ADD0;
      end
      ADD0: begin rsload = mr[0]; state_d = SH0;  end
      SH0:  begin rsshr  = 1'b1;  state_d = ADD1; end
      ADD1: begin rsload = mr[1]; state_d = SH1;  end
      SH1:  begin rsshr  = 1'b1;  state_d = ADD2; end
      ADD2: begin rsload = mr[2]; state_d = SH2;  end
      SH2:  begin rsshr  = 1'b1;  state_d = ADD3; end
      ADD3: begin rsload = mr[3]; state_d = SH3;  end
      SH3:  begin rsshr  = 1'b1;  state_d = DONE; end
      DONE: begin
        done    = 1'b1;
        state_d = start ? DONE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sm_control.sv
// Directed-vector bench for sm_control with hand-computed expected state codes and controls.
module tb_sm_control;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] reset_state = '0;
  logic       start = 1'b0;
  logic [3:0] mr = '0;
  logic       mdld, mrld, rsload, rsclear, rsshr, done;
  logic [3:0] s, n;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  sm_control #(.NUM_BITS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .reset_state (reset_state),
    .start       (start),
    .mr          (mr),
    .mdld        (mdld),
    .mrld        (mrld),
    .rsload      (rsload),
    .rsclear     (rsclear),
    .rsshr       (rsshr),
    .s           (s),
    .n           (n),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Control vector ordering: {mdld, mrld, rsload, rsclear, rsshr, done}
  task automatic check_ctl(input string tag, input logic [5:0] exp_ctl, input logic [3:0] exp_n);
    check({tag, ".ctl"}, int'({mdld, mrld, rsload, rsclear, rsshr, done}), int'(exp_ctl));
    check({tag, ".n"}, int'(n), int'(exp_n));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] st);
    @(negedge clk);
    reset_state = st;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin : main
    logic [15:0] reached;
    logic [15:0] visited;
    int unsigned edges;

    // Power-up into IDLE, then INIT
    start = 1'b0;
    do_reset(4'd0);
    check("reset.s", int'(s), 0);
    check_ctl("idle.nostart", 6'b000000, 4'd0);
    start = 1'b1;
    #1;
    check_ctl("idle.start", 6'b000000, 4'd1);
    tick;
    check("init.s", int'(s), 1);
    check_ctl("init", 6'b110100, 4'd2);

    // ADD0 with mr=0101, then SH0 and ADD1
    start = 1'b0;
    mr = 4'b0101;
    do_reset(4'd2);
    check("add0.s", int'(s), 2);
    check_ctl("add0", 6'b001000, 4'd3);
    tick;
    check("sh0.s", int'(s), 3);
    check_ctl("sh0", 6'b000010, 4'd4);
    start = 1'b1;
    tick;
    check("add1.s", int'(s), 4);
    check_ctl("add1.mr0101", 6'b000000, 4'd5);

    // Remaining ADD/SH states
    do_reset(4'd4);
    check_ctl("add1.reload", 6'b000000, 4'd5);
    do_reset(4'd6);
    check_ctl("add2.mr0101", 6'b001000, 4'd7);
    do_reset(4'd8);
    check_ctl("add3.mr0101", 6'b000000, 4'd9);
    mr = 4'b1000;
    #1;
    check_ctl("add3.mr1000", 6'b001000, 4'd9);
    do_reset(4'd9);
    check_ctl("sh3", 6'b000010, 4'd10);

    // DONE holds while start is high, returns to IDLE after release
    start = 1'b1;
    do_reset(4'd10);
    check_ctl("done.start", 6'b000001, 4'd10);
    tick;
    check("done.hold.s", int'(s), 10);
    start = 1'b0;
    #1;
    check_ctl("done.release", 6'b000001, 4'd0);
    tick;
    check("done.exit.s", int'(s), 0);

    // Illegal code decodes to nothing and recovers to IDLE
    mr = 4'hF;
    start = 1'b1;
    do_reset(4'd13);
    check("illegal.s", int'(s), 13);
    check_ctl("illegal", 6'b000000, 4'd0);
    tick;
    check("illegal.exit.s", int'(s), 0);

    // Asynchronous load follows reset_state while rst is held
    start = 1'b0;
    @(negedge clk);
    #2;
    reset_state = 4'd7;
    rst = 1'b1;
    #1;
    check("async.load.s", int'(s), 7);
    reset_state = 4'd3;
    #1;
    check("async.follow.s", int'(s), 3);
    check_ctl("async.follow", 6'b000010, 4'd4);
    @(negedge clk);
    rst = 1'b0;
    tick;
    check("async.release.s", int'(s), 4);

    // Mid-multiply abort
    start = 1'b1;
    do_reset(4'd0);
    tick; tick; tick;
    check("abort.pre.s", int'(s), 3);
    #2;
    reset_state = 4'd0;
    rst = 1'b1;
    #1;
    check("abort.s", int'(s), 0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick;
    check("abort.after.s", int'(s), 0);

    // Full multiply latency from IDLE
    start = 1'b1;
    mr = 4'b1011;
    do_reset(4'd0);
    edges = 0;
    while (done !== 1'b1 && edges < 20) begin
      tick;
      edges++;
    end
    check("latency.edges", int'(edges), 10);
    check("latency.s", int'(s), 10);
    start = 1'b0;

    // Reachability sweep from IDLE
    reached = 16'h0001;
    visited = '0;
    for (int iter = 0; iter < 16; iter++) begin
      for (int st = 0; st < 16; st++) begin
        if (reached[st] && !visited[st]) begin
          visited[st] = 1'b1;
          for (int m = 0; m < 16; m++) begin
            for (int b = 0; b < 2; b++) begin
              do_reset(4'(st));
              mr = 4'(m);
              start = b[0];
              tick;
              reached[s] = 1'b1;
            end
          end
        end
      end
    end
    check("reach.set", int'(reached), 16'h07FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sm_control.md
SM_CONTROL -- requirements
Module: sm_control

Interface
REQ-001 Parameter NUM_BITS, default 4, multiplier width; this revision supports only NUM_BITS = 4 and uses a 4-bit state code.
REQ-002 clk  input  1  single system clock; all state updates occur on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high; loads the state register from reset_state.
REQ-004 reset_state  input  4  state code loaded while rst is high; 0 gives normal power-up into IDLE.
REQ-005 start  input  1  start request, level-sensitive.
REQ-006 mr  input  4  multiplier register bits from the datapath.
REQ-007 mdld  output  1  load multiplicand register.
REQ-008 mrld  output  1  load multiplier register.
REQ-009 rsload  output  1  load running-sum register (add partial product).
REQ-010 rsclear  output  1  clear running-sum register.
REQ-011 rsshr  output  1  shift running-sum register right by one.
REQ-012 s  output  4  current state code (state register).
REQ-013 n  output  4  combinational next-state code.
REQ-014 done  output  1  multiply complete.

Function
REQ-015 State encoding: IDLE=0, INIT=1, ADD0=2, SH0=3, ADD1=4, SH1=5, ADD2=6, SH2=7, ADD3=8, SH3=9, DONE=10; codes 11-15 are illegal.
REQ-016 State register s SHALL take the value of n on each rising clk edge when rst is low.
REQ-017 IDLE: n=INIT if start=1, else IDLE; all control outputs 0.
REQ-018 INIT: mdld=1, mrld=1, rsclear=1; n=ADD0 unconditionally.
REQ-019 ADDk (k=0..3): rsload=mr[k] (combinational on mr); n=SHk unconditionally.
REQ-020 SHk: rsshr=1; n=ADD(k+1) for k<3, n=DONE for k=3.
REQ-021 DONE: done=1; n=DONE while start=1, n=IDLE when start=0 (start must be released before a new multiply).
REQ-022 Illegal codes 11-15: all control outputs 0, done=0; n=IDLE regardless of inputs.
REQ-023 Outputs not listed as asserted in a state SHALL be 0 in that state; at most one of rsload/rsshr/rsclear asserted at a time.
REQ-024 start is ignored in every state except IDLE and DONE; mr is ignored except in ADDk.
REQ-025 A complete multiply from IDLE with start=1 takes 10 clock edges to reach DONE (IDLE->INIT->ADD0...SH3->DONE).
REQ-026 Outputs and n are purely combinational from s, start and mr; no output registers.

Reset
REQ-027 While rst=1, s SHALL equal reset_state immediately (asynchronously) and follow reset_state changes; outputs decode that state per REQ-017..022.
REQ-028 Reset asserted mid-multiply SHALL abort the operation and load reset_state; no partial-state memory remains.
REQ-029 On rst deassertion the first rising edge applies the normal transition from the loaded state.

Verification
REQ-030 reset_state=0, rst pulse, start=1, one edge -> s=1, mdld=mrld=rsclear=1, n=2.
REQ-031 reset_state=2, mr=4'b0101, rst release, observe ADD0 -> rsload=1, n=3; edge -> s=3, rsshr=1, n=4.
REQ-032 reset_state=4, mr=4'b0101 -> rsload=0 in ADD1; reset_state=9 -> rsshr=1, n=10.
REQ-033 reset_state=10, start=1 -> done=1, n=10; start=0 -> n=0, next edge s=0.
REQ-034 reset_state=13 (illegal), any mr/start -> all outputs 0, n=0; after one edge s=0.
REQ-035 Reachability sweep: from state 0, for every mr (0-15) and start (0/1) load each discovered state via reset_state and clock once; reached set SHALL be exactly {0..10}.
